// File: rtl/yuv_capture_pkg.sv
// ============================================================================
// yuv_capture_pkg : shared states, plane indices and default geometry
// Revision 1.0
// ============================================================================
`default_nettype none

package yuv_capture_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM     = 3'd1;
   localparam logic [2:0] S_SYNC    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   typedef enum logic [1:0] {
      PL_Y = 2'd0,
      PL_U = 2'd1,
      PL_V = 2'd2
   } plane_e;

   localparam int c_H_ACTIVE = 640;
   localparam int c_V_ACTIVE = 480;
   localparam int c_ADDR_W   = 16;
   localparam int c_Y_BASE   = 0;
   localparam int c_U_BASE   = 38400;
   localparam int c_V_BASE   = 48000;
   localparam int c_WORD_W   = 64;

endpackage

`default_nettype wire

// File: rtl/yuv_plane_packer.sv
// ============================================================================
// yuv_plane_packer : byte-lane packer with one-word holding register and counter
// Revision 1.0
// ============================================================================
`default_nettype none

module yuv_plane_packer
   import yuv_capture_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int BASE   = 0
) (
   input  logic                  MIPI_PIXEL_CLK,
   input  logic                  RESET_N,
   input  logic                  i_clear,
   input  logic                  i_en,
   input  logic                  i_complete,
   input  logic [2:0]            i_lane,
   input  logic [7:0]            i_pix,
   input  logic                  i_grant,
   input  logic                  i_accept,
   output logic                  o_valid,
   output logic [c_WORD_W-1:0]   o_word,
   output logic [ADDR_W-1:0]     o_addr,
   output logic                  o_overflow
);

   logic [c_WORD_W-1:0] r_shift;
   logic [c_WORD_W-1:0] r_word;
   logic                r_valid;
   logic [ADDR_W-1:0]   r_count;
   logic [c_WORD_W-1:0] w_merged;
   logic                w_drop;

   always_comb begin
      w_merged = r_shift;
      w_merged[{i_lane, 3'b000} +: 8] = i_pix;
   end

   // A completing word only displaces the held one if that one leaves this cycle
   assign w_drop     = i_complete && r_valid && !i_grant;
   assign o_overflow = w_drop;
   assign o_valid    = r_valid;
   assign o_word     = r_word;
   // The word being granted alongside an acceptance of this plane goes one slot further
   assign o_addr     = ADDR_W'(BASE) + r_count + ADDR_W'(i_accept);

   always_ff @(posedge MIPI_PIXEL_CLK) begin
      if (!RESET_N) begin
         r_shift <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         if (i_en)
            r_shift <= w_merged;
         if (i_accept)
            r_count <= r_count + 1'b1;
         if (i_complete && !w_drop) begin
            r_word  <= w_merged;
            r_valid <= 1'b1;
         end else if (i_grant) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/yuv_capture_sched.sv
// ============================================================================
// yuv_capture_sched : frame capture FSM and Y>U>V write-port scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

module yuv_capture_sched
   import yuv_capture_pkg::*;
#(
   parameter int H_ACTIVE = c_H_ACTIVE,
   parameter int V_ACTIVE = c_V_ACTIVE,
   parameter int ADDR_W   = c_ADDR_W,
   parameter int Y_BASE   = c_Y_BASE,
   parameter int U_BASE   = c_U_BASE,
   parameter int V_BASE   = c_V_BASE
) (
   input  logic              MIPI_PIXEL_CLK,
   input  logic              RESET_N,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              short_frame,
   input  logic              frame_vs,
   input  logic              pix_valid,
   input  logic [7:0]        Y,
   input  logic [7:0]        U,
   input  logic [7:0]        V,
   output logic              wren,
   output logic [ADDR_W-1:0] wraddress,
   output logic [63:0]       data,
   input  logic              wr_ready
);

   localparam int c_COL_W = $clog2(H_ACTIVE);
   localparam int c_ROW_W = $clog2(V_ACTIVE);

   logic [2:0]          r_state;
   logic [c_COL_W-1:0]  r_col;
   logic [c_ROW_W-1:0]  r_row;
   logic                r_overflow;
   logic                r_short;
   logic                r_wren;
   logic [ADDR_W-1:0]   r_wraddress;
   logic [63:0]         r_data;
   plane_e              r_plane;

   logic                w_pix;
   logic                w_col_last;
   logic                w_row_last;
   logic                w_uv_en;
   logic                w_clear;
   logic                w_free;
   logic                w_gnt_any;
   plane_e              w_sel;
   logic [2:0]          w_en;
   logic [2:0]          w_cpl;
   logic [2:0]          w_valid;
   logic [2:0]          w_grant;
   logic [2:0]          w_acc;
   logic [2:0]          w_ovf;
   logic [2:0]          w_lane [3];
   logic [7:0]          w_byte [3];
   logic [63:0]         w_word [3];
   logic [ADDR_W-1:0]   w_addr [3];

   assign w_pix      = (r_state == S_CAPTURE) && pix_valid && !frame_vs;
   assign w_col_last = (r_col == c_COL_W'(H_ACTIVE - 1));
   assign w_row_last = (r_row == c_ROW_W'(V_ACTIVE - 1));
   assign w_uv_en    = w_pix && !r_row[0] && !r_col[0];
   assign w_clear    = (r_state == S_IDLE) && start;

   assign w_en[PL_Y]   = w_pix;
   assign w_cpl[PL_Y]  = w_pix && (r_col[2:0] == 3'd7);
   assign w_lane[PL_Y] = r_col[2:0];
   assign w_byte[PL_Y] = Y;
   assign w_en[PL_U]   = w_uv_en;
   assign w_cpl[PL_U]  = w_uv_en && (r_col[3:0] == 4'd14);
   assign w_lane[PL_U] = r_col[3:1];
   assign w_byte[PL_U] = U;
   assign w_en[PL_V]   = w_uv_en;
   assign w_cpl[PL_V]  = w_uv_en && (r_col[3:0] == 4'd14);
   assign w_lane[PL_V] = r_col[3:1];
   assign w_byte[PL_V] = V;

   // The output register can take a word if empty or emptying this cycle
   assign w_free    = !r_wren || wr_ready;
   assign w_gnt_any = w_free && (|w_valid);

   always_comb begin
      w_sel = PL_V;
      if (w_valid[PL_Y])
         w_sel = PL_Y;
      else if (w_valid[PL_U])
         w_sel = PL_U;
   end

   for (genvar i = 0; i < 3; i++) begin : g_plane
      localparam int c_BASE = (i == 0) ? Y_BASE : ((i == 1) ? U_BASE : V_BASE);

      assign w_grant[i] = w_gnt_any && (w_sel == plane_e'(i));
      assign w_acc[i]   = r_wren && wr_ready && (r_plane == plane_e'(i));

      yuv_plane_packer #(
         .ADDR_W (ADDR_W),
         .BASE   (c_BASE)
      ) u_packer (
         .MIPI_PIXEL_CLK (MIPI_PIXEL_CLK),
         .RESET_N        (RESET_N),
         .i_clear        (w_clear),
         .i_en           (w_en[i]),
         .i_complete     (w_cpl[i]),
         .i_lane         (w_lane[i]),
         .i_pix          (w_byte[i]),
         .i_grant        (w_grant[i]),
         .i_accept       (w_acc[i]),
         .o_valid        (w_valid[i]),
         .o_word         (w_word[i]),
         .o_addr         (w_addr[i]),
         .o_overflow     (w_ovf[i])
      );
   end

   always_ff @(posedge MIPI_PIXEL_CLK) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_col      <= '0;
         r_row      <= '0;
         r_overflow <= 1'b0;
         r_short    <= 1'b0;
      end else begin
         if (|w_ovf)
            r_overflow <= 1'b1;
         case (r_state)
            S_IDLE: if (start) begin
               r_state    <= S_ARM;
               r_col      <= '0;
               r_row      <= '0;
               r_overflow <= 1'b0;
               r_short    <= 1'b0;
            end
            S_ARM:  if (frame_vs)  r_state <= S_SYNC;
            S_SYNC: if (!frame_vs) r_state <= S_CAPTURE;
            S_CAPTURE: begin
               if (frame_vs) begin
                  r_state <= S_DRAIN;
                  r_short <= 1'b1;
               end else if (pix_valid) begin
                  if (w_col_last) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                     if (w_row_last)
                        r_state <= S_DRAIN;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            S_DRAIN: if (!(|w_valid) && !r_wren) r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge MIPI_PIXEL_CLK) begin
      if (!RESET_N) begin
         r_wren      <= 1'b0;
         r_wraddress <= '0;
         r_data      <= '0;
         r_plane     <= PL_Y;
      end else if (w_gnt_any) begin
         r_wren      <= 1'b1;
         r_wraddress <= w_addr[w_sel];
         r_data      <= w_word[w_sel];
         r_plane     <= w_sel;
      end else if (wr_ready) begin
         r_wren      <= 1'b0;
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign overflow    = r_overflow;
   assign short_frame = r_short;
   assign wren        = r_wren;
   assign wraddress   = r_wraddress;
   assign data        = r_data;

endmodule

`default_nettype wire

// File: tb/tb_yuv_capture_sched.sv
// ============================================================================
// tb_yuv_capture_sched : directed/random frame bench with plane-word reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_yuv_capture_sched;

   localparam int H   = 32;
   localparam int V   = 120;
   localparam int UB  = 480;
   localparam int VB  = 600;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        short_frame;
   logic        frame_vs;
   logic        pix_valid;
   logic [7:0]  y, u, v;
   logic        wren;
   logic [15:0] wraddress;
   logic [63:0] data;
   logic        wr_ready;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int t7 = 0;

   logic [15:0] wa [$];
   logic [63:0] wd [$];
   int          wc [$];

   logic [7:0] py [V][H];
   logic [7:0] pu [V][H];
   logic [7:0] pv [V][H];

   yuv_capture_sched #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .ADDR_W   (16),
      .Y_BASE   (0),
      .U_BASE   (UB),
      .V_BASE   (VB)
   ) dut (
      .MIPI_PIXEL_CLK (clk),
      .RESET_N        (rst_n),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .overflow       (overflow),
      .short_frame    (short_frame),
      .frame_vs       (frame_vs),
      .pix_valid      (pix_valid),
      .Y              (y),
      .U              (u),
      .V              (v),
      .wren           (wren),
      .wraddress      (wraddress),
      .data           (data),
      .wr_ready       (wr_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && wren && wr_ready) begin
         wa.push_back(wraddress);
         wd.push_back(data);
         wc.push_back(cyc);
      end
      if (done)
         done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      done_cnt = 0;
   endtask

   function automatic int plane_of(input logic [15:0] a);
      return (a < 16'(UB)) ? 0 : ((a < 16'(VB)) ? 1 : 2);
   endfunction

   function automatic int first_of(input int p);
      for (int i = 0; i < wa.size(); i++)
         if (plane_of(wa[i]) == p) return i;
      return -1;
   endfunction

   function automatic int last_of(input int p);
      int k = -1;
      for (int i = 0; i < wa.size(); i++)
         if (plane_of(wa[i]) == p) k = i;
      return k;
   endfunction

   function automatic logic [63:0] qa(input int i);
      return (i >= 0 && i < wa.size()) ? 64'(wa[i]) : '1;
   endfunction

   function automatic logic [63:0] qd(input int i);
      return (i >= 0 && i < wd.size()) ? wd[i] : '1;
   endfunction

   function automatic logic [63:0] qc(input int i);
      return (i >= 0 && i < wc.size()) ? 64'(wc[i]) : '1;
   endfunction

   // Word k of a plane, built straight from the captured pixel grid
   function automatic logic [63:0] exp_word(input int p, input int k);
      logic [63:0] w = '0;
      int r, c0;
      if (p == 0) begin
         r  = k / (H / 8);
         c0 = (k % (H / 8)) * 8;
         for (int b = 0; b < 8; b++) w[8*b +: 8] = py[r][c0 + b];
      end else begin
         r  = 2 * (k / (H / 16));
         c0 = (k % (H / 16)) * 16;
         for (int b = 0; b < 8; b++)
            w[8*b +: 8] = (p == 1) ? pu[r][c0 + 2*b] : pv[r][c0 + 2*b];
      end
      return w;
   endfunction

   task automatic check_frame(input string tag, input int nrows);
      int base, nexp, j, bad;
      for (int p = 0; p < 3; p++) begin
         base = (p == 0) ? 0 : ((p == 1) ? UB : VB);
         nexp = (p == 0) ? nrows * (H / 8) : ((nrows + 1) / 2) * (H / 16);
         j = 0;
         bad = 0;
         for (int i = 0; i < wa.size(); i++) begin
            if (plane_of(wa[i]) == p) begin
               if (j >= nexp || int'(wa[i]) != base + j || wd[i] !== exp_word(p, j))
                  bad++;
               j++;
            end
         end
         check($sformatf("%s plane%0d count", tag, p), 64'(j), 64'(nexp));
         check($sformatf("%s plane%0d bad words", tag, p), 64'(bad), 64'd0);
      end
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == 0 && k < 4000) begin
         tick();
         k++;
      end
      check({tag, " done seen"}, 64'(done_cnt > 0), 64'd1);
      repeat (5) tick();
   endtask

   // mode 0: Y=col,U=40,V=C0 full rate; 1: random data, every other cycle; 2: random data/valid/ready
   task automatic drive_frame(input string tag, input int nrows, input int mode, input int stall_row,
                              input int stall_len, input bit mid_start, input bit do_start);
      int  r = 0, c = 0, stall = 0;
      bit  ph = 1'b0;
      logic vld;
      if (do_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      frame_vs = 1'b1;
      repeat (4) tick();
      frame_vs = 1'b0;
      repeat (2) tick();
      while (r < nrows) begin
         ph  = ~ph;
         vld = (mode == 0) ? 1'b1 : ((mode == 1) ? ph : ($urandom_range(3) != 0));
         if (vld && r == stall_row && c == H / 2) stall = stall_len;
         wr_ready = (stall > 0) ? 1'b0 : ((mode == 2) ? ($urandom_range(7) != 0) : 1'b1);
         if (stall > 0) stall--;
         start     = mid_start && vld && r == 5 && c == 0;
         pix_valid = vld;
         if (mode == 0) begin
            y = 8'(c);
            u = 8'h40;
            v = 8'hC0;
         end else begin
            y = 8'($urandom);
            u = 8'($urandom);
            v = 8'($urandom);
         end
         if (vld) begin
            py[r][c] = y;
            pu[r][c] = u;
            pv[r][c] = v;
            if (r == 0 && c == 7) t7 = cyc;
         end
         tick();
         if (vld) begin
            if (c == H - 1) begin
               c = 0;
               r++;
            end else begin
               c++;
            end
         end
      end
      pix_valid = 1'b0;
      start     = 1'b0;
      wr_ready  = 1'b1;
      frame_vs  = 1'b1;
      wait_done(tag);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; frame_vs = 1'b0; pix_valid = 1'b0;
      y = '0; u = '0; v = '0; wr_ready = 1'b1;
      repeat (3) tick();
      check("reset wren", 64'(wren), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset overflow", 64'(overflow), 64'd0);
      check("reset short_frame", 64'(short_frame), 64'd0);
      check("reset wraddress", 64'(wraddress), 64'd0);
      check("reset data", data, 64'd0);
      rst_n = 1'b1;
      tick();

      // Frame A: known pattern, port always ready
      clear_log();
      drive_frame("A", V, 0, -1, 0, 1'b0, 1'b1);
      check_frame("A", V);
      check("A total writes", 64'(wa.size()), 64'd720);
      check("A first Y addr", qa(first_of(0)), 64'd0);
      check("A first Y data", qd(first_of(0)), 64'h0706050403020100);
      check("A last Y addr", qa(last_of(0)), 64'd479);
      check("A first U addr", qa(first_of(1)), 64'(UB));
      check("A first U data", qd(first_of(1)), 64'h4040404040404040);
      check("A first V addr", qa(first_of(2)), 64'(VB));
      check("A first V data", qd(first_of(2)), 64'hC0C0C0C0C0C0C0C0);
      check("A first write latency", qc(0) - 64'(t7), 64'd2);
      check("A done count", 64'(done_cnt), 64'd1);
      check("A overflow", 64'(overflow), 64'd0);
      check("A busy after done", 64'(busy), 64'd0);

      // Frame B: half-rate pixels, U,V,Y burst order around col 14/15
      clear_log();
      drive_frame("B", V, 1, -1, 0, 1'b0, 1'b1);
      check_frame("B", V);
      check("B write1 addr U", qa(1), 64'(UB));
      check("B write2 addr V", qa(2), 64'(VB));
      check("B write3 addr Y1", qa(3), 64'd1);
      check("B U->V gap", qc(2) - qc(1), 64'd1);
      check("B V->Y gap", qc(3) - qc(2), 64'd1);

      // Frame C: start mid-frame, start while busy, 3-cycle stall, random traffic
      clear_log();
      frame_vs = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      pix_valid = 1'b1;
      repeat (50) begin
         y = 8'($urandom);
         tick();
      end
      pix_valid = 1'b0;
      check("C armed busy", 64'(busy), 64'd1);
      check("C no writes before sync", 64'(wa.size()), 64'd0);
      drive_frame("C", V, 2, 2, 3, 1'b1, 1'b0);
      check_frame("C", V);
      check("C overflow", 64'(overflow), 64'd0);
      check("C done count", 64'(done_cnt), 64'd1);

      // Frame E: 40-cycle stall forces drops
      clear_log();
      drive_frame("E", V, 0, 1, 40, 1'b0, 1'b1);
      check("E overflow sticky", 64'(overflow), 64'd1);
      check("E done count", 64'(done_cnt), 64'd1);

      // Frame F: vertical blanking after row 99
      clear_log();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("F overflow cleared", 64'(overflow), 64'd0);
      drive_frame("F", 100, 2, -1, 0, 1'b0, 1'b0);
      check("F short_frame", 64'(short_frame), 64'd1);
      check("F done count", 64'(done_cnt), 64'd1);
      check("F last Y addr", qa(last_of(0)), 64'd399);
      check_frame("F", 100);

      // Frame G: reset during capture, then a clean frame
      clear_log();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("G short_frame cleared", 64'(short_frame), 64'd0);
      frame_vs = 1'b1;
      repeat (3) tick();
      frame_vs = 1'b0;
      tick();
      pix_valid = 1'b1;
      repeat (3 * H) begin
         y = 8'($urandom);
         tick();
      end
      pix_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      check("G wren after reset", 64'(wren), 64'd0);
      check("G busy after reset", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      clear_log();
      drive_frame("G", V, 0, -1, 0, 1'b0, 1'b1);
      check("G first write addr", qa(0), 64'd0);
      check_frame("G", V);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/yuv_capture_sched.md
# yuv_capture_sched

Frame-capture controller and write-port scheduler between the camera colour-conversion path (per-pixel Y/U/V bytes) and the single 64-bit frame-buffer write port. On a processor `start` it arms, waits for a frame boundary, and counts one full frame. It packs Y at full resolution and U/V 4:2:0-subsampled into 8-byte words and arbitrates the three planes onto the one write port. It reports `busy`/`done` and error flags.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 16.
- `V_ACTIVE`, 480: active lines per frame; must be even.
- `ADDR_W`, 16: word-address width.
- `Y_BASE`, 0: Y plane base word address.
- `U_BASE`, 38400: U plane base word address.
- `V_BASE`, 48000: V plane base word address.

Ports:
- `MIPI_PIXEL_CLK`  in  1  sole clock; every register is in this domain.
- `RESET_N`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to capture the next frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the frame is fully written.
- `overflow`  out  1  sticky: a plane word was dropped. Cleared on an accepted `start`.
- `short_frame`  out  1  sticky: `frame_vs` rose before the last pixel. Cleared on an accepted `start`.
- `frame_vs`  in  1  high during vertical blanking.
- `pix_valid`  in  1  qualifies Y/U/V for one pixel.
- `Y`, `U`, `V`  in  8 each  pixel components.
- `wren`  out  1  write strobe.
- `wraddress`  out  ADDR_W  word address.
- `data`  out  64  write data; byte lane k is `data[8k+7:8k]`.
- `wr_ready`  in  1  port accepts the current word when `wren && wr_ready`.

## Operation
State machine and transitions:
- IDLE: `start` → ARM. Counters and word counts are cleared and sticky flags are cleared.
- ARM: `frame_vs`=1 → SYNC. This prevents joining a frame mid-way.
- SYNC: `frame_vs`=0 → CAPTURE.
- CAPTURE: `pix_valid` advances `col`.
  - At `col`=H_ACTIVE-1, `col` wraps to 0 and `row` increments.
  - Accepting pixel (V_ACTIVE-1, H_ACTIVE-1) → DRAIN.
  - `frame_vs`=1 before that pixel → DRAIN and set `short_frame`.
- DRAIN: all holding registers empty and the output register idle → DONE.
- DONE: assert `done` for one cycle → IDLE.
- `start` outside IDLE is ignored.

Packing:
- Y: every pixel, lane `col[2:0]`. The word completes at `col[2:0]`=7.
- U and V: only on even `row` and even `col`, lane `col[3:1]`. Both words complete at `col[3:0]`=14, in the same cycle.

Scheduling:
- Each plane has a one-word holding register, a valid bit, and a word counter.
- Address = base + count. The count increments when the word is accepted at the write port.
- Fixed priority Y > U > V grants one valid holding register into the output register. A grant occurs only when the output register is empty or is being accepted in the same cycle.
- A word completes while its holding register is valid and not granted that cycle → the new word is dropped, the old word is kept, and `overflow` is set.

Arithmetic:
- Word counts are ADDR_W bits and have no wrap check. The base parameters must keep the planes disjoint.
- With default parameters: 38400 Y words, 9600 U words, 9600 V words.

## Timing
- Reset values: `wren`, `busy`, `done`, `overflow` and `short_frame` are 0. `wraddress` and `data` are 0.
- Reset clears the state to IDLE, invalidates all holding registers, and zeroes row, col and all counts. This holds mid-capture too; in-flight words are discarded.
- `wren`, `wraddress` and `data` are registered. The last pixel of a word is accepted in cycle N, the holding register is valid in N+1, and with no contention `wren` is high in N+2.
- `wren` stays high with stable `wraddress` and `data` until `wr_ready`. No grant is made while the port is stalled.
- Sustained `wr_ready`=1 never overflows. The col 14 (U,V) and col 15 (Y) bursts drain within 3 cycles.
- `done` is asserted one cycle after DRAIN empties. `busy` falls in the same cycle as `done`.

## Structure
- Package `yuv_capture_pkg`:
  - state enum: IDLE, ARM, SYNC, CAPTURE, DRAIN, DONE
  - plane index enum: Y, U, V
  - default geometry and base constants
- Sub-module `yuv_plane_packer`, instantiated three times. It holds the lane shift-in, the holding register and valid bit, the word counter, and the overflow detect.
- The top level holds the FSM, row/col counters, the priority arbiter, and the output register.

## Test plan
- Full frame with Y=`col[7:0]`, U=0x40, V=0xC0 and `wr_ready`=1. Required response:
  - 57600 writes in total.
  - First Y write is addr 0, data 0x0706050403020100; last Y write is addr 38399.
  - First U write is addr 38400, data 0x4040404040404040; first V write is addr 48000.
  - Exactly one `done`; `overflow`=0.
- Row 0, col 14 → U then V on consecutive cycles, followed by the col 15 Y word (addr 1). Order is U, V, Y.
- `wr_ready`=0 for 3 cycles mid-line → no `overflow`, all addresses contiguous. `wr_ready`=0 for 40 cycles → `overflow`=1, stays set after `done`, cleared on the next `start`.
- `start` pulsed mid-frame (`frame_vs`=0) → no writes until after the next `frame_vs` high-to-low. A second `start` while `busy` → ignored.
- `frame_vs` rises after row 99 → DRAIN, `short_frame`=1, `done` pulses, last Y addr = 100×80−1 = 7999.
- `RESET_N` low for one cycle during CAPTURE → `wren`=0 and `busy`=0 at the next edge. The next `start` plus a frame → first write at addr 0.
